// File: rtl/jk_multimode_register.sv
// jk_multimode_register: WIDTH-bit JK register bank with hold/JK/modulo count/load/shift/complement modes
module jk_multimode_register #(
  parameter int               WIDTH     = 4,
  parameter int               MODULUS   = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic             en_i,
  input  logic [2:0]       mode_i,
  input  logic [WIDTH-1:0] j_i,
  input  logic [WIDTH-1:0] k_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             ser_in_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] qn_o,
  output logic             tc_o,
  output logic             wrap_o
);
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);
  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  // next state per mode; up-count treats anything at or above TOP as the wrap point
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (en_i) begin
      case (mode_i)
        3'b001: q_d = (j_i & ~q_q) | (~k_i & q_q);
        3'b010: begin
          q_d    = (q_q >= TOP) ? '0 : q_q + 1'b1;
          wrap_d = q_q >= TOP;
        end
        3'b011: begin
          q_d    = (q_q == '0) ? TOP : q_q - 1'b1;
          wrap_d = q_q == '0;
        end
        3'b100: q_d = d_i;
        3'b101: q_d = WIDTH'({q_q, ser_in_i});
        3'b110: q_d = WIDTH'({ser_in_i, q_q} >> 1);
        3'b111: q_d = ~q_q;
        default: q_d = q_q;
      endcase
    end
  end
  // state register with synchronous active-low reset overriding everything
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      q_q    <= RESET_VAL;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end
  assign q_o    = q_q;
  assign qn_o   = ~q_q;
  assign wrap_o = wrap_q;
  assign tc_o   = en_i & ((mode_i == 3'b010 & q_q == TOP) | (mode_i == 3'b011 & q_q == '0));
endmodule

// File: tb/tb_jk_multimode_register.sv
// tb_jk_multimode_register: vector table plus randomized model check of jk_multimode_register
module tb_jk_multimode_register;
  localparam int MOD = 10;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst_n = 1'b0, en = 1'b0, ser = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [3:0] j = '0, k = '0, d = '0;
  logic [3:0] q, qn, q5, qn5;
  logic       tc, wrap, tc5, wrap5;
  int checks = 0, errors = 0;

  jk_multimode_register #(.WIDTH(4), .MODULUS(MOD), .RESET_VAL(4'd0)) dut (
    .clock_i(clk), .reset_n_i(rst_n), .en_i(en), .mode_i(mode), .j_i(j), .k_i(k),
    .d_i(d), .ser_in_i(ser), .q_o(q), .qn_o(qn), .tc_o(tc), .wrap_o(wrap));
  jk_multimode_register #(.WIDTH(4), .MODULUS(MOD), .RESET_VAL(4'd5)) dut5 (
    .clock_i(clk), .reset_n_i(rst_n), .en_i(en), .mode_i(mode), .j_i(j), .k_i(k),
    .d_i(d), .ser_in_i(ser), .q_o(q5), .qn_o(qn5), .tc_o(tc5), .wrap_o(wrap5));

  typedef struct {
    logic r, e; logic [2:0] m; logic [3:0] j, k, d; logic s;
    logic tc; logic [3:0] q; logic w;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic r, input logic e, input logic [2:0] m,
                              input logic [3:0] jj, input logic [3:0] kk, input logic [3:0] dd,
                              input logic s, input logic t, input logic [3:0] eq, input logic w);
    vec_t v;
    v = '{r, e, m, jj, kk, dd, s, t, eq, w};
    tbl.push_back(v);
  endfunction

  function automatic int model_next(input int cur, input int rv, input logic r, input logic e,
                                    input logic [2:0] m, input int jj, input int kk, input int dd,
                                    input logic s, output bit w);
    int n, qb, jb, kb;
    w = 0;
    if (!r) return rv;
    if (!e) return cur;
    case (m)
      3'd1: begin
        n = 0;
        for (int b = 0; b < 4; b++) begin
          qb = (cur >> b) & 1; jb = (jj >> b) & 1; kb = (kk >> b) & 1;
          if (jb == 1 && kb == 1) qb = 1 - qb;
          else if (jb == 1) qb = 1;
          else if (kb == 1) qb = 0;
          n += qb << b;
        end
        return n;
      end
      3'd2: begin
        if (cur >= MOD - 1) begin w = 1; return 0; end
        return cur + 1;
      end
      3'd3: begin
        if (cur == 0) begin w = 1; return MOD - 1; end
        return cur - 1;
      end
      3'd4: return dd;
      3'd5: return (cur * 2 + int'(s)) % 16;
      3'd6: return cur / 2 + int'(s) * 8;
      3'd7: return 15 - cur;
      default: return cur;
    endcase
  endfunction

  initial begin
    int mq, mq5, nq, nq5;
    bit w, w5;
    logic [3:0] eqn;
    // up-count from 0 through the wrap: 1..9, 0, 1, 2
    for (int i = 1; i <= 12; i++)
      add(1, 1, 3'd2, 0, 0, 0, 0, (i == 10), 4'((i - 1) % 10 == 9 ? 0 : i % 10), (i == 10));
    add(0, 1, 3'd3, 0, 0, 0, 0, 0, 4'h0, 0);
    add(1, 1, 3'd3, 0, 0, 0, 0, 1, 4'h9, 1);
    add(1, 1, 3'd3, 0, 0, 0, 0, 0, 4'h8, 0);
    add(1, 1, 3'd3, 0, 0, 0, 0, 0, 4'h7, 0);
    add(1, 1, 3'd4, 0, 0, 4'hC, 0, 0, 4'hC, 0);
    add(1, 1, 3'd2, 0, 0, 0, 0, 0, 4'h0, 1);
    add(1, 1, 3'd4, 0, 0, 4'hC, 0, 0, 4'hC, 0);
    add(1, 1, 3'd3, 0, 0, 0, 0, 0, 4'hB, 0);
    add(1, 1, 3'd3, 0, 0, 0, 0, 0, 4'hA, 0);
    add(1, 1, 3'd3, 0, 0, 0, 0, 0, 4'h9, 0);
    add(1, 1, 3'd4, 0, 0, 4'h5, 0, 0, 4'h5, 0);
    add(1, 1, 3'd1, 4'hC, 4'hA, 0, 0, 0, 4'hD, 0);
    add(1, 1, 3'd4, 0, 0, 4'h0, 0, 0, 4'h0, 0);
    add(1, 1, 3'd5, 0, 0, 0, 1, 0, 4'h1, 0);
    add(1, 1, 3'd5, 0, 0, 0, 0, 0, 4'h2, 0);
    add(1, 1, 3'd5, 0, 0, 0, 1, 0, 4'h5, 0);
    add(1, 1, 3'd5, 0, 0, 0, 1, 0, 4'hB, 0);
    add(1, 1, 3'd6, 0, 0, 0, 0, 0, 4'h5, 0);
    add(1, 1, 3'd7, 0, 0, 0, 0, 0, 4'hA, 0);
    add(1, 1, 3'd4, 0, 0, 4'h9, 0, 0, 4'h9, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 3'd2, 0, 0, 0, 0, 0, 4'h9, 0);
    add(1, 1, 3'd4, 0, 0, 4'h7, 0, 0, 4'h7, 0);
    add(0, 1, 3'd2, 0, 0, 0, 0, 0, 4'h0, 0);
    add(1, 1, 3'd4, 0, 0, 4'h9, 0, 0, 4'h9, 0);
    add(0, 1, 3'd2, 0, 0, 0, 0, 1, 4'h0, 0);
    add(1, 1, 3'd3, 0, 0, 0, 0, 1, 4'h9, 1);
    add(1, 1, 3'd2, 0, 0, 0, 0, 1, 4'h0, 1);
    add(1, 1, 3'd3, 0, 0, 0, 0, 1, 4'h9, 1);
    add(1, 1, 3'd4, 0, 0, 4'hF, 0, 0, 4'hF, 0);
    add(1, 1, 3'd3, 0, 0, 0, 0, 0, 4'hE, 0);
    add(1, 1, 3'd1, 4'hF, 4'hF, 0, 0, 0, 4'h1, 0);

    // reset held for two edges while counting is requested
    @(negedge clk); rst_n = 0; en = 1; mode = 3'd2;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_q", q, 4'h0);
    chk("reset_wrap", wrap, 1'b0);
    chk("reset_qn", qn, 4'hF);
    chk("reset_q_rv5", q5, 4'h5);
    chk("reset_qn_rv5", qn5, 4'hA);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst_n = tbl[i].r; en = tbl[i].e; mode = tbl[i].m;
      j = tbl[i].j; k = tbl[i].k; d = tbl[i].d; ser = tbl[i].s;
      #1;
      chk($sformatf("vec%0d_tc", i), tc, tbl[i].tc);
      @(posedge clk);
      #1;
      eqn = ~tbl[i].q;
      chk($sformatf("vec%0d_q", i), q, tbl[i].q);
      chk($sformatf("vec%0d_qn", i), qn, eqn);
      chk($sformatf("vec%0d_wrap", i), wrap, tbl[i].w);
    end

    @(negedge clk); rst_n = 0;
    @(posedge clk); #1;
    mq = 0; mq5 = 5;
    chk("rand_start_q5", q5, 4'h5);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 19) != 0);
      en    = ($urandom_range(0, 7) != 0);
      mode  = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(2, 3)) : 3'($urandom_range(0, 7));
      j = 4'($urandom); k = 4'($urandom); d = 4'($urandom); ser = 1'($urandom);
      #1;
      chk("rand_tc", tc, en && ((mode == 3'd2 && mq == MOD - 1) || (mode == 3'd3 && mq == 0)));
      chk("rand_tc_rv5", tc5, en && ((mode == 3'd2 && mq5 == MOD - 1) || (mode == 3'd3 && mq5 == 0)));
      nq  = model_next(mq, 0, rst_n, en, mode, j, k, d, ser, w);
      nq5 = model_next(mq5, 5, rst_n, en, mode, j, k, d, ser, w5);
      @(posedge clk);
      #1;
      mq = nq; mq5 = nq5;
      chk("rand_q", q, mq);
      chk("rand_qn", qn, 15 - mq);
      chk("rand_wrap", wrap, w);
      chk("rand_q_rv5", q5, mq5);
      chk("rand_wrap_rv5", wrap5, w5);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/jk_multimode_register.md
Name: jk_multimode_register

Overview:
- Parametrised successor to the single-bit asynchronous JK flip-flop.
- A WIDTH-bit bank of JK-style storage with a synchronous mode select: hold, per-bit JK, modulo up/down count, parallel load, bidirectional shift and complement.
- Serves as the general-purpose register/counter primitive for later lab designs such as sequence generators and modulo-N counters.
- Single clock domain; all state changes happen on the rising Clock edge.

Parameters:
- WIDTH, 4: number of storage bits.
- MODULUS, 16: count modulus. Legal range 2..2^WIDTH. Applies to the count modes only.
- RESET_VAL, 0: value loaded into Q by reset. Must be < 2^WIDTH.

Ports:
- Clock  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  synchronous, active-low reset.
- En  input  1  clock enable; when 0, Q holds.
- Mode  input  3  operation select, encoded under Behaviour.
- J  input  WIDTH  per-bit J inputs; used in mode 001 only.
- K  input  WIDTH  per-bit K inputs; used in mode 001 only.
- D  input  WIDTH  parallel load data.
- SerIn  input  1  serial input for the shift modes.
- Q  output  WIDTH  register state.
- Qn  output  WIDTH  bitwise complement of Q (combinational).
- TC  output  1  terminal count (combinational).
- Wrap  output  1  registered one-cycle pulse indicating a count wrap occurred.

Behaviour:
- Reset is synchronous and active-low. At a rising Clock edge with Reset=0:
  - Q <= RESET_VAL and Wrap <= 0.
  - Reset overrides En and Mode.
  - A reset arriving mid-count simply discards the count state. No pending effect remains.
- With Reset=1 and En=0: Q holds and Wrap <= 0.
- With Reset=1 and En=1, the next Q depends on Mode:
  - 000 hold: Q unchanged.
  - 001 JK: each bit i is evaluated independently.
    - J=0,K=0: hold.
    - J=0,K=1: clear to 0.
    - J=1,K=0: set to 1.
    - J=1,K=1: toggle.
  - 010 count up: if Q >= MODULUS-1 then Q <= 0, else Q <= Q+1. Out-of-range values (>= MODULUS), for example from a load, wrap to 0 on the next up-count.
  - 011 count down: if Q == 0 then Q <= MODULUS-1, else Q <= Q-1. Out-of-range values decrement normally until they re-enter the range.
  - 100 load: Q <= D. No masking to MODULUS is applied.
  - 101 shift left: Q <= {Q[WIDTH-2:0], SerIn}.
  - 110 shift right: Q <= {SerIn, Q[WIDTH-1:1]}.
  - 111 complement: Q <= ~Q.
- Wrap:
  - Wrap <= 1 on an edge where an enabled up-count went from Q >= MODULUS-1 to 0, or an enabled down-count went from 0 to MODULUS-1.
  - Otherwise Wrap <= 0. It is therefore exactly one cycle wide per wrap.
- TC is combinational from current Q, Mode and En:
  - 1 when En=1, Mode=010 and Q == MODULUS-1.
  - 1 when En=1, Mode=011 and Q == 0.
  - 0 otherwise.
  - TC=1 predicts a wrap at the next edge.
- Qn = ~Q at all times, including during reset.
- Arithmetic is WIDTH bits wide with no carry out. Comparisons are unsigned.
- Latency: one Clock edge from input change to Q. Wrap lags the wrapping edge by zero cycles, meaning it is valid in the cycle after that edge alongside the new Q.
- A Mode change takes effect at the next edge with no pipeline. Switching between up and down on consecutive cycles is legal.
- Inputs are sampled only at the rising edge. There is no asynchronous path to Q.

Test Plan (WIDTH=4, MODULUS=10, RESET_VAL=0 unless stated):
- Reset=0 for 2 edges with En=1, Mode=010 -> Q=0, Wrap=0, Qn=4'hF. Release Reset, up-count 12 edges -> Q sequence 1..9, 0, 1, 2. TC=1 while Q=9. Wrap=1 for exactly one cycle, coincident with the first Q=0.
- Mode=011 from Q=0 -> Q=9 with Wrap=1. Then 8,7,... Load D=4'hC (mode 100), then up-count -> Q=0 with Wrap=1. Load 4'hC, then down-count -> Q=B, A, 9.
- Mode=001 from Q=4'b0101 with J=4'b1100, K=4'b1010 -> bit3 toggles to 1, bit2 set stays 1, bit1 cleared stays 0, bit0 holds 1. Result Q=4'b1101.
- Shift left with SerIn 1,0,1,1 from Q=0 -> Q=0001, 0010, 0101, 1011. Shift right with SerIn=0 -> 0101. Complement -> 1010.
- En=0 with Mode=010 at Q=9 -> Q stays 9, TC=0, Wrap=0 across 3 edges.
- Assert Reset=0 at Q=7 mid-count with En=1 -> next edge Q=0, Wrap=0. Rebuild with RESET_VAL=5 -> Q=5 after reset.
